// File: rtl/instruction_fetch_unit_if.sv
// Bundle of fetch-unit signals: control-unit handshake, PC redirect and instruction RAM port.
// The master modport is the fetch unit; the slave modport is its environment.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned INSTR_WIDTH = 19
);
    logic                   fetch_req;
    logic                   pc_load;
    logic [ADDR_WIDTH-1:0]  pc_in;
    logic [INSTR_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic                   mem_read;
    logic                   mem_write;
    logic [INSTR_WIDTH-1:0] ir;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   instr_valid;
    logic                   busy;

    modport master (
        input  fetch_req, pc_load, pc_in, mem_data,
        output mem_address, mem_read, mem_write, ir, pc, instr_valid, busy
    );

    modport slave (
        output fetch_req, pc_load, pc_in, mem_data,
        input  mem_address, mem_read, mem_write, ir, pc, instr_valid, busy
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Multicycle front end: owns the PC, reads the instruction RAM with a fixed latency and
// captures the word into IR. Redirects arriving mid-fetch are deferred until the fetch ends.
module instruction_fetch_unit #(
    parameter int unsigned          ADDR_WIDTH  = 10,
    parameter int unsigned          INSTR_WIDTH = 19,
    parameter int unsigned          MEM_LAT     = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]  pend_pc_q, pend_pc_d;
    logic [3:0]             lat_cnt_q, lat_cnt_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        lat_cnt_d = lat_cnt_q;

        unique case (state_q)
            StIdle: begin
                // A redirect wins over a request so the next fetch uses the new PC.
                if (bus.pc_load) begin
                    pc_d = bus.pc_in;
                end else if (bus.fetch_req) begin
                    lat_cnt_d = LatInit;
                    state_d   = StRead;
                end
            end
            StRead: begin
                if (bus.pc_load) begin
                    pend_d    = 1'b1;
                    pend_pc_d = bus.pc_in;
                end
                if (lat_cnt_q != 4'd0) begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end else begin
                    ir_d    = bus.mem_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // A load seen in this very cycle is newer than any stored one.
                if (bus.pc_load) begin
                    pc_d = bus.pc_in;
                end else if (pend_q) begin
                    pc_d = pend_pc_q;
                end
                pend_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            lat_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign bus.mem_address = pc_q;
    assign bus.mem_read    = (state_q == StRead);
    assign bus.mem_write   = 1'b0;
    assign bus.ir          = ir_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = (state_q == StDone);
    assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: one fetch unit with MEM_LAT=1 and one with MEM_LAT=3, each reading a
// behavioural instruction RAM whose contents come from ram_word().
module tb_instruction_fetch_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    instruction_fetch_unit_if #(.ADDR_WIDTH(10), .INSTR_WIDTH(19)) ifa ();
    instruction_fetch_unit_if #(.ADDR_WIDTH(10), .INSTR_WIDTH(19)) ifb ();

    instruction_fetch_unit #(
        .ADDR_WIDTH (10),
        .INSTR_WIDTH(19),
        .MEM_LAT    (1),
        .RESET_PC   (10'd0)
    ) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    instruction_fetch_unit #(
        .ADDR_WIDTH (10),
        .INSTR_WIDTH(19),
        .MEM_LAT    (3),
        .RESET_PC   (10'd0)
    ) u_dut3 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    function automatic logic [18:0] ram_word(input logic [9:0] a);
        if (a == 10'd0) return 19'h1A2B3;
        return {a[8:0], a} ^ 19'h35C71;
    endfunction

    assign ifa.mem_data = ram_word(ifa.mem_address);
    assign ifb.mem_data = ram_word(ifb.mem_address);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Redirect B's PC while idle.
    task automatic load_b(input logic [9:0] addr);
        ifb.pc_load = 1'b1;
        ifb.pc_in   = addr;
        @(negedge clk);
        ifb.pc_load = 1'b0;
        check("load_pc", 32'(ifb.pc), 32'(addr));
    endtask

    // One plain fetch on B starting from IDLE at a negedge.
    task automatic fetch_b(input logic [9:0] addr);
        logic [9:0] nxt;
        int         n;
        nxt           = addr + 10'd1;
        ifb.fetch_req = 1'b1;
        @(negedge clk);
        ifb.fetch_req = 1'b0;
        check("fb_addr", 32'(ifb.mem_address), 32'(addr));
        check("fb_rd", 32'(ifb.mem_read), 32'd1);
        n = 0;
        while (!ifb.instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fb_lat", 32'(n), 32'd3);
        check("fb_ir", 32'(ifb.ir), 32'(ram_word(addr)));
        check("fb_pc", 32'(ifb.pc), 32'(nxt));
        @(negedge clk);
        check("fb_idle", 32'(ifb.busy), 32'd0);
        check("fb_valid_off", 32'(ifb.instr_valid), 32'd0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        ifa.fetch_req = 1'b0;
        ifa.pc_load   = 1'b0;
        ifa.pc_in     = '0;
        ifb.fetch_req = 1'b0;
        ifb.pc_load   = 1'b0;
        ifb.pc_in     = '0;
        repeat (2) @(negedge clk);

        check("rst_pc", 32'(ifa.pc), 32'd0);
        check("rst_ir", 32'(ifa.ir), 32'd0);
        check("rst_rd", 32'(ifa.mem_read), 32'd0);
        check("rst_wr", 32'(ifa.mem_write), 32'd0);
        check("rst_valid", 32'(ifa.instr_valid), 32'd0);
        check("rst_busy", 32'(ifa.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MEM_LAT=1 single fetch from address 0.
        ifa.fetch_req = 1'b1;
        @(negedge clk);
        ifa.fetch_req = 1'b0;
        check("l1_rd", 32'(ifa.mem_read), 32'd1);
        check("l1_addr", 32'(ifa.mem_address), 32'd0);
        check("l1_valid_early", 32'(ifa.instr_valid), 32'd0);
        check("l1_wr", 32'(ifa.mem_write), 32'd0);
        @(negedge clk);
        check("l1_valid", 32'(ifa.instr_valid), 32'd1);
        check("l1_ir", 32'(ifa.ir), 32'h1A2B3);
        check("l1_pc", 32'(ifa.pc), 32'd1);
        check("l1_rd_off", 32'(ifa.mem_read), 32'd0);
        check("l1_wr2", 32'(ifa.mem_write), 32'd0);
        @(negedge clk);
        check("l1_valid_off", 32'(ifa.instr_valid), 32'd0);
        check("l1_busy", 32'(ifa.busy), 32'd0);
        check("l1_ir_hold", 32'(ifa.ir), 32'h1A2B3);

        // MEM_LAT=3 with fetch_req held: READ,READ,READ,DONE,IDLE repeating.
        ifb.fetch_req = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("l3_rd", 32'(ifb.mem_read), 32'((k % 5) < 3));
            check("l3_valid", 32'(ifb.instr_valid), 32'((k % 5) == 3));
            if ((k % 5) == 3) begin
                check("l3_ir", 32'(ifb.ir), 32'(ram_word(10'(k / 5))));
                check("l3_pc", 32'(ifb.pc), 32'(k / 5 + 1));
            end
            if (k == 13) ifb.fetch_req = 1'b0;
        end
        @(negedge clk);
        check("l3_idle", 32'(ifb.busy), 32'd0);

        // Load together with fetch_req in IDLE: load wins, no fetch.
        ifb.pc_load   = 1'b1;
        ifb.pc_in     = 10'd516;
        ifb.fetch_req = 1'b1;
        @(negedge clk);
        ifb.pc_load   = 1'b0;
        ifb.fetch_req = 1'b0;
        check("ld_pc", 32'(ifb.pc), 32'd516);
        check("ld_nofetch", 32'(ifb.busy), 32'd0);
        fetch_b(10'd516);

        // Wrap at the top of the address space.
        load_b(10'd1023);
        fetch_b(10'd1023);

        // Load during READ is deferred to the DONE->IDLE edge.
        load_b(10'd5);
        ifb.fetch_req = 1'b1;
        @(negedge clk);
        ifb.fetch_req = 1'b0;
        ifb.pc_load   = 1'b1;
        ifb.pc_in     = 10'd40;
        @(negedge clk);
        ifb.pc_load = 1'b0;
        repeat (2) @(negedge clk);
        check("pend_valid", 32'(ifb.instr_valid), 32'd1);
        check("pend_ir", 32'(ifb.ir), 32'(ram_word(10'd5)));
        check("pend_pc_done", 32'(ifb.pc), 32'd6);
        @(negedge clk);
        check("pend_pc", 32'(ifb.pc), 32'd40);
        fetch_b(10'd40);

        // Two loads while busy: the last one wins.
        ifb.fetch_req = 1'b1;
        @(negedge clk);
        ifb.fetch_req = 1'b0;
        ifb.pc_load   = 1'b1;
        ifb.pc_in     = 10'd40;
        @(negedge clk);
        ifb.pc_in = 10'd41;
        @(negedge clk);
        ifb.pc_load = 1'b0;
        @(negedge clk);
        check("two_valid", 32'(ifb.instr_valid), 32'd1);
        check("two_ir", 32'(ifb.ir), 32'(ram_word(10'd41)));
        check("two_pc_done", 32'(ifb.pc), 32'd42);
        @(negedge clk);
        check("two_pc", 32'(ifb.pc), 32'd41);

        // Load asserted in the DONE cycle itself.
        ifb.fetch_req = 1'b1;
        @(negedge clk);
        ifb.fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        check("dl_valid", 32'(ifb.instr_valid), 32'd1);
        ifb.pc_load = 1'b1;
        ifb.pc_in   = 10'd100;
        @(negedge clk);
        ifb.pc_load = 1'b0;
        check("dl_pc", 32'(ifb.pc), 32'd100);
        check("dl_idle", 32'(ifb.busy), 32'd0);

        // Asynchronous reset in the middle of a READ.
        load_b(10'd7);
        ifb.fetch_req = 1'b1;
        @(negedge clk);
        ifb.fetch_req = 1'b0;
        check("ar_rd", 32'(ifb.mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_pc", 32'(ifb.pc), 32'd0);
        check("ar_ir", 32'(ifb.ir), 32'd0);
        check("ar_rd_off", 32'(ifb.mem_read), 32'd0);
        check("ar_busy", 32'(ifb.busy), 32'd0);
        check("ar_addr", 32'(ifb.mem_address), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ar_novalid", 32'(ifb.instr_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_hold_ir", 32'(ifb.ir), 32'd0);
        fetch_b(10'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
